// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry block: key layout, scan classification
// and the lower limits on the timing parameters.
package keypad_entry_pkg;

    localparam int MIN_SCAN_DIV = 4;
    localparam int MIN_DEBOUNCE = 1;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } key_class_e;

    typedef struct packed {
        key_class_e cls;
        logic [3:0] pos;   // row*4 + col of the pressed key, zero unless SINGLE
    } scan_result_t;

    // Indexed by row*4 + col.
    localparam logic [3:0] KEY_LAYOUT [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic scan_result_t classify(input logic [15:0] map);
        scan_result_t r;
        int n;
        r.cls = NONE;
        r.pos = '0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (map[i]) begin
                n++;
                r.pos = 4'(i);
            end
        end
        if (n == 1) r.cls = SINGLE;
        else if (n > 1) r.cls = MULTI;
        if (n != 1) r.pos = '0;
        return r;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Entry-side signals between the keypad block and the control block that consumes the value.
interface keypad_entry_if;
    import keypad_entry_pkg::*;

    // key_strobe is a one-cycle valid with no ready: key_code/userInput are valid in that
    // cycle. clear is the consumer's one-cycle pulse; it may coincide with a strobe.
    logic        clear;
    logic [15:0] userInput;
    logic        inputValid;
    logic        key_strobe;
    logic [3:0]  key_code;

    modport master (
        input  clear,
        output userInput,
        output inputValid,
        output key_strobe,
        output key_code
    );

    modport slave (
        output clear,
        input  userInput,
        input  inputValid,
        input  key_strobe,
        input  key_code
    );

endinterface

// File: rtl/keypad_scanner.sv
// Column scan driver with row synchroniser; assembles one 16-bit raw key map per full scan.
module keypad_scanner
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  col_n,
    input  logic [3:0]  row_n,
    output logic [15:0] map,
    output logic        map_valid
);

    localparam int DW = $clog2(SCAN_DIV);

    if (SCAN_DIV < MIN_SCAN_DIV) begin : g_bad_scan_div
        $error("SCAN_DIV below minimum");
    end

    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [11:0]   cap;    // columns 0..2, bit col*4 + row, active-high pressed
    logic          last;

    assign last      = (dwell == DW'(SCAN_DIV - 1));
    assign map_valid = last && (col == 2'd3);
    assign col_n     = ~(4'b0001 << col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell <= '0;
            col   <= 2'd0;
            sync1 <= 4'hF;
            sync2 <= 4'hF;
            cap   <= '0;
        end else begin
            sync1 <= row_n;
            sync2 <= sync1;
            if (last) begin
                dwell <= '0;
                col   <= col + 2'd1;
                if (col != 2'd3) cap[{col, 2'b00} +: 4] <= ~sync2;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    // Column 3 is taken straight from the synchroniser on the scan's final cycle.
    always_comb begin
        map = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 3) map[r*4 + c] = ~sync2[r];
                else        map[r*4 + c] = cap[c*4 + r];
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Hex keypad entry: debounces scan results, strobes new key presses and shifts digits
// into a 16-bit value that the control block reads and clears.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [3:0]        col_n,
    input  logic [3:0]        row_n,
    keypad_entry_if.master    entry,
    output key_class_e        dbg_state
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    if (DEBOUNCE < MIN_DEBOUNCE) begin : g_bad_debounce
        $error("DEBOUNCE below minimum");
    end

    logic [15:0]  map;
    logic         map_valid;
    scan_result_t res;
    scan_result_t acc, acc_next;
    scan_result_t prev, prev_next;
    logic [CW-1:0] cnt, cnt_next;
    logic         press;
    logic [15:0]  user_q;
    logic [2:0]   digits;
    logic         strobe_q;
    logic [3:0]   code_q;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .map       (map),
        .map_valid (map_valid)
    );

    assign res = classify(map);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '{cls: NONE, pos: 4'd0};
            prev <= '{cls: NONE, pos: 4'd0};
            cnt  <= '0;
        end else begin
            acc  <= acc_next;
            prev <= prev_next;
            cnt  <= cnt_next;
        end
    end

    // Multi-key scans leave the whole debounce state untouched.
    always_comb begin
        acc_next  = acc;
        prev_next = prev;
        cnt_next  = cnt;
        press     = 1'b0;
        if (map_valid && res.cls != MULTI) begin
            prev_next = res;
            if (res != acc && res == prev) begin
                if (cnt == CW'(DEBOUNCE - 1)) begin
                    acc_next = res;
                    cnt_next = '0;
                    press    = (acc.cls == NONE) && (res.cls == SINGLE);
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            user_q   <= '0;
            digits   <= 3'd0;
            strobe_q <= 1'b0;
            code_q   <= 4'h0;
        end else begin
            strobe_q <= press;
            if (press) begin
                code_q <= KEY_LAYOUT[res.pos];
                user_q <= {(entry.clear ? 12'h000 : user_q[11:0]), KEY_LAYOUT[res.pos]};
                if (entry.clear)        digits <= 3'd1;
                else if (digits != 3'd4) digits <= digits + 3'd1;
            end else if (entry.clear) begin
                // A clear landing on the strobe cycle keeps the digit just typed.
                if (strobe_q) begin
                    user_q <= {12'h000, code_q};
                    digits <= 3'd1;
                end else begin
                    user_q <= '0;
                    digits <= 3'd0;
                end
            end
        end
    end

    assign entry.userInput  = user_q;
    assign entry.inputValid = (digits != 3'd0);
    assign entry.key_strobe = strobe_q;
    assign entry.key_code   = code_q;
    assign dbg_state        = acc.cls;

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled (min 4).
REQ-002 DEBOUNCE, 4, consecutive identical full scans needed to accept a key state change (min 1).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 col_n  out  4  column drive; exactly one bit low, the rest high.
REQ-006 row_n  in  4  row sense, active-low, pulled up, asynchronous to clk.
REQ-007 clear  in  1  one-cycle pulse; discards the entry (driven when the control block consumes userInput).
REQ-008 userInput  out  16  entered hex value; the last digit typed sits in bits [3:0].
REQ-009 inputValid  out  1  high while at least one digit has been entered since reset or clear.
REQ-010 key_strobe  out  1  one-cycle pulse per accepted key press.
REQ-011 key_code  out  4  hex digit of the last accepted key; held between strobes.

Function
REQ-012 row_n SHALL pass through a 2-flop synchroniser before any use.
REQ-013 Scan: a column index cycles 0,1,2,3,0,...; col_n[i] is low while the index is i.
- Each column is held SCAN_DIV cycles.
- Synchronised rows are sampled on the last cycle of the dwell.
- One full scan = 4 dwells.
REQ-014 At each scan end, the 16-bit raw key map SHALL be classified as:
- none: no bits set;
- single: exactly one bit set, giving its row and column;
- multi: two or more bits set.
REQ-015 Multi SHALL be treated as identical to the previous classification; it never starts or resets a debounce count.
REQ-016 Debounce: a counter advances each scan whose classification differs from the accepted state and matches the previous scan. The state is accepted when the counter reaches DEBOUNCE. Any other scan result clears the counter.
REQ-017 An accepted transition from none to single SHALL pulse key_strobe exactly once, on the cycle after the scan end. A single-to-none transition, or a key held down, SHALL produce no strobe.
REQ-018 Key layout (row0..row3, col0..col3): 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
REQ-019 On strobe, userInput SHALL update in that same cycle to {userInput[11:0], key_code}. Digits beyond four shift the oldest out with no saturation.
REQ-020 A digit counter (0..4) SHALL increment on each strobe and saturate at 4; inputValid = (counter != 0).
REQ-021 On clear alone, userInput SHALL become 0 and the counter 0 on the next edge.
REQ-022 If clear and a strobe fall in the same cycle: userInput = {12'h000, key_code}, counter = 1, inputValid stays high.
REQ-023 Clear SHALL NOT disturb the scan, the debounce state, or key_code.

Reset
REQ-024 While rst is high:
- col_n = 4'b1110 (column 0);
- userInput = 0, inputValid = 0, key_strobe = 0, key_code = 0;
- accepted state = none; debounce, dwell and digit counters = 0; synchronisers = 4'hF.
REQ-025 Reset asserted mid-scan or mid-debounce SHALL abandon the scan with no strobe. Scanning restarts at column 0 on the first edge after release.

Structure
REQ-026 A shared package SHALL hold the 16-entry layout table, the classification enumeration (NONE, SINGLE, MULTI) and the minimum-parameter constants.
REQ-027 One sub-module, keypad_scanner, SHALL contain the column drive, row synchroniser and raw-map capture, and emit a map-valid pulse per scan.
REQ-028 Debounce, digit assembly and the outputs SHALL live in keypad_entry.

Verification (SCAN_DIV=4, DEBOUNCE=2)
REQ-029 Press row1/col2 (key 6) for 5 scans -> one key_strobe, key_code=6, userInput=16'h0006, inputValid=1.
REQ-030 Keys 1,2,3,A,B, each pressed and released cleanly -> userInput=16'h23AB, counter stays at 4, five strobes.
REQ-031 Press toggling on alternate scans for 6 scans (bounce) -> no strobe; then stable for 3 scans -> exactly one strobe.
REQ-032 Hold key 5, then add key 9 -> multi state, no new strobe; release 9, keep 5 -> no strobe; release all, press 9 -> one strobe, code 9.
REQ-033 userInput=16'h0012 with clear pulsed on the strobe cycle of key F -> userInput=16'h000F, inputValid=1; clear alone afterwards -> 0 and inputValid=0.
REQ-034 Assert rst during the second debounce scan of key 7 -> no strobe, outputs at reset values, col_n=4'b1110; after release, press 7 again -> normal strobe.
